riscv_control_unit: RTL and testbench



---
 rtl/riscv_control_unit.sv | 141 ++++++++++++++
 tb/tb_riscv_control_unit.sv | 103 ++++++++++
 2 files changed

// File: rtl/riscv_control_unit.sv
// Registered main + ALU decoder for a single-cycle RV32I datapath.
// Each control output takes its decoded value one clock after the instruction fields are presented.
module riscv_control_unit (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    input  logic       zero,
    output logic       pcSrc,
    output logic [1:0] resultSrc,
    output logic       memWrite,
    output logic       aluSrc,
    output logic [1:0] immSrc,
    output logic       regWrite,
    output logic [2:0] aluControl
);

    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    localparam logic [1:0] ALUOP_ADD  = 2'b00;
    localparam logic [1:0] ALUOP_SUB  = 2'b01;
    localparam logic [1:0] ALUOP_FUNC = 2'b10;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    logic       branch;
    logic       jump;
    logic [1:0] alu_op;

    logic       pc_src_d,      pc_src_q;
    logic [1:0] result_src_d,  result_src_q;
    logic       mem_write_d,   mem_write_q;
    logic       alu_src_d,     alu_src_q;
    logic [1:0] imm_src_d,     imm_src_q;
    logic       reg_write_d,   reg_write_q;
    logic [2:0] alu_control_d, alu_control_q;

    // Main decoder: unrecognised opcodes fall through to an all-zero no-op.
    always_comb begin
        reg_write_d  = 1'b0;
        imm_src_d    = 2'b00;
        alu_src_d    = 1'b0;
        mem_write_d  = 1'b0;
        result_src_d = 2'b00;
        branch       = 1'b0;
        jump         = 1'b0;
        alu_op       = ALUOP_ADD;
        case (op)
            OP_LW: begin
                reg_write_d  = 1'b1;
                alu_src_d    = 1'b1;
                result_src_d = 2'b01;
            end
            OP_SW: begin
                imm_src_d   = 2'b01;
                alu_src_d   = 1'b1;
                mem_write_d = 1'b1;
            end
            OP_RTYPE: begin
                reg_write_d = 1'b1;
                alu_op      = ALUOP_FUNC;
            end
            OP_ITYPE: begin
                reg_write_d = 1'b1;
                alu_src_d   = 1'b1;
                alu_op      = ALUOP_FUNC;
            end
            OP_BEQ: begin
                imm_src_d = 2'b10;
                branch    = 1'b1;
                alu_op    = ALUOP_SUB;
            end
            OP_JAL: begin
                reg_write_d  = 1'b1;
                imm_src_d    = 2'b11;
                result_src_d = 2'b10;
                jump         = 1'b1;
            end
            default: ;
        endcase
        pc_src_d = (branch & zero) | jump;
    end

    // ALU decoder: subtract on funct3 000 only for R-type with funct7[5] set, so addi always adds.
    always_comb begin
        alu_control_d = ALU_ADD;
        case (alu_op)
            ALUOP_ADD: alu_control_d = ALU_ADD;
            ALUOP_SUB: alu_control_d = ALU_SUB;
            ALUOP_FUNC: begin
                case (funct3)
                    3'b000:  alu_control_d = (op[5] & funct7[5]) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control_d = ALU_SLT;
                    3'b110:  alu_control_d = ALU_OR;
                    3'b111:  alu_control_d = ALU_AND;
                    default: alu_control_d = ALU_ADD;
                endcase
            end
            default: alu_control_d = ALU_ADD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_src_q      <= 1'b0;
            result_src_q  <= 2'b00;
            mem_write_q   <= 1'b0;
            alu_src_q     <= 1'b0;
            imm_src_q     <= 2'b00;
            reg_write_q   <= 1'b0;
            alu_control_q <= 3'b000;
        end else begin
            pc_src_q      <= pc_src_d;
            result_src_q  <= result_src_d;
            mem_write_q   <= mem_write_d;
            alu_src_q     <= alu_src_d;
            imm_src_q     <= imm_src_d;
            reg_write_q   <= reg_write_d;
            alu_control_q <= alu_control_d;
        end
    end

    assign pcSrc      = pc_src_q;
    assign resultSrc  = result_src_q;
    assign memWrite   = mem_write_q;
    assign aluSrc     = alu_src_q;
    assign immSrc     = imm_src_q;
    assign regWrite   = reg_write_q;
    assign aluControl = alu_control_q;

endmodule

// File: tb/tb_riscv_control_unit.sv
// Directed bench for riscv_control_unit: one registered decode per step, checked against hand-packed control words.
module tb_riscv_control_unit;

    logic       clk;
    logic       rst;
    logic [6:0] op;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       zero;
    logic       pcSrc;
    logic [1:0] resultSrc;
    logic       memWrite;
    logic       aluSrc;
    logic [1:0] immSrc;
    logic       regWrite;
    logic [2:0] aluControl;

    int checks   = 0;
    int failures = 0;

    riscv_control_unit dut (
        .clk        (clk),
        .rst        (rst),
        .op         (op),
        .funct3     (funct3),
        .funct7     (funct7),
        .zero       (zero),
        .pcSrc      (pcSrc),
        .resultSrc  (resultSrc),
        .memWrite   (memWrite),
        .aluSrc     (aluSrc),
        .immSrc     (immSrc),
        .regWrite   (regWrite),
        .aluControl (aluControl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Control word layout: {pcSrc, resultSrc, memWrite, aluSrc, immSrc, regWrite, aluControl}
    function automatic logic [10:0] cw(input logic pc, input logic [1:0] rs, input logic mw,
                                       input logic as, input logic [1:0] imm, input logic rw,
                                       input logic [2:0] alu);
        return {pc, rs, mw, as, imm, rw, alu};
    endfunction

    // Present inputs away from the edge, clock once, then compare just after the edge.
    task automatic step(input string tag, input logic r, input logic [6:0] o, input logic [2:0] f3,
                        input logic [6:0] f7, input logic z, input logic [10:0] exp);
        logic [10:0] got;
        @(negedge clk);
        rst = r; op = o; funct3 = f3; funct7 = f7; zero = z;
        @(posedge clk);
        #1;
        got = {pcSrc, resultSrc, memWrite, aluSrc, immSrc, regWrite, aluControl};
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: observed pc=%b rs=%b mw=%b as=%b imm=%b rw=%b alu=%b expected %b",
                   tag, got[10], got[9:8], got[7], got[6], got[5:4], got[3], got[2:0], exp);
        end
        $display("step %-14s rst=%b op=%0d f3=%b f7=%b z=%b -> %b (exp %b)", tag, r, o, f3, f7, z, got, exp);
    endtask

    initial begin
        rst = 1'b1; op = 7'd0; funct3 = 3'd0; funct7 = 7'd0; zero = 1'b0;

        step("reset1",     1'b1, 7'd51,  3'b111, 7'd0,        1'b1, cw(0, 2'b00, 0, 0, 2'b00, 0, 3'b000));
        step("reset2",     1'b1, 7'd51,  3'b111, 7'd0,        1'b1, cw(0, 2'b00, 0, 0, 2'b00, 0, 3'b000));
        step("r_after_rst",1'b0, 7'd51,  3'b111, 7'd0,        1'b1, cw(0, 2'b00, 0, 0, 2'b00, 1, 3'b010));

        step("lw",         1'b0, 7'd3,   3'b000, 7'd0,        1'b1, cw(0, 2'b01, 0, 1, 2'b00, 1, 3'b000));

        step("r_and",      1'b0, 7'd51,  3'b111, 7'd0,        1'b1, cw(0, 2'b00, 0, 0, 2'b00, 1, 3'b010));
        step("r_sub",      1'b0, 7'd51,  3'b000, 7'b0110000,  1'b1, cw(0, 2'b00, 0, 0, 2'b00, 1, 3'b001));
        step("r_add",      1'b0, 7'd51,  3'b000, 7'd0,        1'b1, cw(0, 2'b00, 0, 0, 2'b00, 1, 3'b000));
        step("r_or",       1'b0, 7'd51,  3'b110, 7'd0,        1'b1, cw(0, 2'b00, 0, 0, 2'b00, 1, 3'b011));
        step("r_slt",      1'b0, 7'd51,  3'b010, 7'd0,        1'b1, cw(0, 2'b00, 0, 0, 2'b00, 1, 3'b101));
        step("r_f3_001",   1'b0, 7'd51,  3'b001, 7'b0100000,  1'b0, cw(0, 2'b00, 0, 0, 2'b00, 1, 3'b000));
        step("r_sub_f7lo", 1'b0, 7'd51,  3'b000, 7'b0011111,  1'b0, cw(0, 2'b00, 0, 0, 2'b00, 1, 3'b000));

        step("beq_taken",  1'b0, 7'd99,  3'b111, 7'd0,        1'b1, cw(1, 2'b00, 0, 0, 2'b10, 0, 3'b001));
        step("beq_not",    1'b0, 7'd99,  3'b111, 7'd0,        1'b0, cw(0, 2'b00, 0, 0, 2'b10, 0, 3'b001));
        step("beq_zero_up",1'b0, 7'd99,  3'b111, 7'd0,        1'b1, cw(1, 2'b00, 0, 0, 2'b10, 0, 3'b001));

        step("jal_z0",     1'b0, 7'd111, 3'b010, 7'd0,        1'b0, cw(1, 2'b10, 0, 0, 2'b11, 1, 3'b000));
        step("jal_z1",     1'b0, 7'd111, 3'b110, 7'b0100000,  1'b1, cw(1, 2'b10, 0, 0, 2'b11, 1, 3'b000));
        step("sw",         1'b0, 7'd35,  3'b010, 7'd0,        1'b1, cw(0, 2'b00, 1, 1, 2'b01, 0, 3'b000));

        step("addi_f7sub", 1'b0, 7'd19,  3'b000, 7'b0100000,  1'b1, cw(0, 2'b00, 0, 1, 2'b00, 1, 3'b000));
        step("andi",       1'b0, 7'd19,  3'b111, 7'd0,        1'b0, cw(0, 2'b00, 0, 1, 2'b00, 1, 3'b010));
        step("illegal0",   1'b0, 7'd0,   3'b111, 7'b1111111,  1'b1, cw(0, 2'b00, 0, 0, 2'b00, 0, 3'b000));
        step("illegal127", 1'b0, 7'd127, 3'b000, 7'b0100000,  1'b1, cw(0, 2'b00, 0, 0, 2'b00, 0, 3'b000));

        step("pre_midrst", 1'b0, 7'd111, 3'b000, 7'd0,        1'b1, cw(1, 2'b10, 0, 0, 2'b11, 1, 3'b000));
        step("mid_reset",  1'b1, 7'd35,  3'b000, 7'd0,        1'b1, cw(0, 2'b00, 0, 0, 2'b00, 0, 3'b000));
        step("post_midrst",1'b0, 7'd3,   3'b000, 7'd0,        1'b0, cw(0, 2'b01, 0, 1, 2'b00, 1, 3'b000));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
